sha_state_bank: RTL and testbench
=================================

# sha_state_bank

- Parametrised SHA-256 working-variable register bank holding a..h for the hashing core; also sequences the round count and the final feed-forward addition.
- Loads the intermediate hash on a start pulse and shifts in new a/e words from the round logic once per enabled cycle.
- After ROUNDS rounds it adds the saved intermediate hash to the working variables and presents the digest under a valid/ack handshake.
- Sits between the message-schedule/compression datapath and the nonce-check logic; replaces the fixed single-word load registers.

## Interface
- WORD_W, 32, bits per working word
- NUM_WORDS, 8, working words; even, >= 4; word[NUM_WORDS/2] is the "e" insertion point
- ROUNDS, 64, rounds per block; >= 2
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- start  input  1  load h_in into working and saved-H registers
- h_in  input  NUM_WORDS*WORD_W  intermediate hash; word k at bits [k*WORD_W +: WORD_W]
- round_en  input  1  perform one round shift this cycle
- new_a  input  WORD_W  new word[0] from compression logic
- new_e  input  WORD_W  new word[NUM_WORDS/2]
- digest_ack  input  1  consumer has taken digest
- state_out  output  NUM_WORDS*WORD_W  current working words, same packing as h_in
- round_cnt  output  $clog2(ROUNDS)  rounds completed in current block
- busy  output  1  high in RUN or FOLD
- digest_out  output  NUM_WORDS*WORD_W  saved H + working words
- digest_valid  output  1  digest_out valid

## Operation
- FSM states: IDLE, RUN, FOLD, DONE.
- IDLE: start -> load working words and saved-H from h_in, round_cnt=0, go RUN.
- RUN, round_en=1:
  - word[0]<=new_a; word[NUM_WORDS/2]<=new_e; every other word[k]<=word[k-1].
  - round_cnt++.
  - If round_cnt==ROUNDS-1 before the increment: round_cnt wraps to 0, go FOLD.
- RUN, round_en=0: hold all state (stall); no limit on stall length.
- FOLD: one cycle; digest word k <= saved_H[k] + word[k] mod 2^WORD_W (carry discarded per word); go DONE.
- DONE: digest_valid=1; digest_out and state_out held until acknowledged or restarted.
  - digest_ack alone -> IDLE, digest_valid=0.
  - start (with or without digest_ack) -> start wins: reload from h_in, go RUN, digest_valid=0.
- start ignored in RUN and FOLD. round_en ignored outside RUN. digest_ack ignored outside DONE.

## Timing
- Reset values (asynchronous, on rst_n low): state IDLE; all working, saved-H and digest registers 0; round_cnt=0; busy=0; digest_valid=0.
- Reset mid-RUN or mid-FOLD aborts the block; no digest is produced.
- Start edge = E0. With round_en held high:
  - Rounds occur on E1..E(ROUNDS).
  - FOLD edge is E(ROUNDS+1); digest_valid is high after that edge.
- Total latency is ROUNDS+2 edges from start to valid, plus one edge per stalled cycle.
- All outputs are registered; no combinational input-to-output path.
- state_out shows the post-edge working words. round_cnt counts 0..ROUNDS-1.

## Configuration
- Macro: SHA_STATE_BANK_MIDSTATE_CACHE_EN.
- Defined:
  - Adds input reuse_mid (1 bit). When start and reuse_mid are both high, working and saved-H registers load from the cached saved-H instead of h_in.
  - The cache is saved-H itself, retained across blocks and cleared only by reset.
  - Lets the miner restart with a new nonce without re-driving h_in.
- Undefined: the reuse_mid port is absent; start always loads from h_in.

## Test plan
- Reset: assert rst_n=0 mid-RUN (ROUNDS=4, after 2 rounds) -> state_out=0, busy=0, digest_valid=0 immediately, without waiting for a clock edge.
- Basic (ROUNDS=4): h_in words 1..8, new_a=0xA, new_e=0xE, round_en=1 -> after E4 state_out words 0xA,0xA,0xA,0xA,0xE,0xE,0xE,0xE; after E5 digest 0xB,0xC,0xD,0xE,0x13,0x14,0x15,0x16, digest_valid=1.
- Stall: same as basic with round_en low for 3 cycles after round 2 -> round_cnt holds at 2; digest_valid rises 3 cycles later than basic, same digest.
- Wrap: h_in all 0xFFFFFFFF, new_a=new_e=1, ROUNDS=4 -> every digest word 0x00000000.
- Handshake:
  - Hold digest_ack=0 for 5 cycles in DONE -> digest_valid and digest_out stable.
  - Then start and digest_ack together -> RUN entered, digest_valid=0, working words = new h_in.
- Midstate (macro defined): after the basic run, start with reuse_mid=1 and h_in=0 -> working words 1..8 reloaded from the cache.

Source files
------------

// File: rtl/sha_state_bank.sv
// sha_state_bank
//   SHA-256 working-variable register bank (a..h) for the hashing core.
//   Loads the intermediate hash on start, shifts in new a/e words once per
//   enabled round, then folds the saved intermediate hash into the working
//   words and presents the digest under a valid/ack handshake.
//
// Parameters
//   WORD_W     bits per working word
//   NUM_WORDS  number of working words (even, >= 4); word[NUM_WORDS/2] is "e"
//   ROUNDS     rounds per block (>= 2)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         load h_in into working and saved-H registers (IDLE/DONE)
//   reuse_mid     (SHA_STATE_BANK_MIDSTATE_CACHE_EN only) reload from saved-H
//   h_in          intermediate hash, word k at [k*WORD_W +: WORD_W]
//   round_en      perform one round shift this cycle (RUN only)
//   new_a, new_e  new word[0] / word[NUM_WORDS/2] from the compression logic
//   digest_ack    consumer has taken the digest (DONE only)
//   state_out     current working words, same packing as h_in
//   round_cnt     rounds completed in the current block
//   busy          high in RUN or FOLD
//   digest_out    saved H + working words, per-word modulo 2^WORD_W
//   digest_valid  digest_out valid (DONE)
//
// Configuration macro: SHA_STATE_BANK_MIDSTATE_CACHE_EN
//   When defined, adds reuse_mid; start with reuse_mid high reloads the
//   working and saved-H registers from saved-H itself (the midstate cache).

module sha_state_bank #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8,
  parameter int ROUNDS    = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
`ifdef SHA_STATE_BANK_MIDSTATE_CACHE_EN
  input  logic                          reuse_mid,
`endif
  input  logic [NUM_WORDS*WORD_W-1:0]   h_in,
  input  logic                          round_en,
  input  logic [WORD_W-1:0]             new_a,
  input  logic [WORD_W-1:0]             new_e,
  input  logic                          digest_ack,
  output logic [NUM_WORDS*WORD_W-1:0]   state_out,
  output logic [$clog2(ROUNDS)-1:0]     round_cnt,
  output logic                          busy,
  output logic [NUM_WORDS*WORD_W-1:0]   digest_out,
  output logic                          digest_valid
);

  localparam int CNT_W = $clog2(ROUNDS);
  localparam int E_IDX = NUM_WORDS / 2;

  typedef enum logic [1:0] {IDLE, RUN, FOLD, DONE} state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] work   [NUM_WORDS];
  logic [WORD_W-1:0] saved  [NUM_WORDS];
  logic [WORD_W-1:0] digest [NUM_WORDS];
  logic [WORD_W-1:0] load_word [NUM_WORDS];
  logic [CNT_W-1:0]  cnt_q;

  logic load_now;
  logic round_now;
  logic last_round;

  assign load_now   = start && (state_q == IDLE || state_q == DONE);
  assign round_now  = (state_q == RUN) && round_en;
  assign last_round = (cnt_q == CNT_W'(ROUNDS - 1));

  // Load source: normally h_in; with the midstate cache, saved-H can be
  // reloaded onto itself so a restart needs no fresh h_in.
  always_comb begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      load_word[k] = h_in[k*WORD_W +: WORD_W];
`ifdef SHA_STATE_BANK_MIDSTATE_CACHE_EN
      if (reuse_mid) begin
        load_word[k] = saved[k];
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Start has priority over ack in DONE; a stall in RUN simply holds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (round_en && last_round) state_d = FOLD;
      FOLD: state_d = DONE;
      DONE: begin
        if (start) begin
          state_d = RUN;
        end else if (digest_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Working/saved/digest datapath. The shift index uses a modular form so
  // word 0 never references a negative index (word 0 takes new_a anyway).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        work[k]   <= '0;
        saved[k]  <= '0;
        digest[k] <= '0;
      end
      cnt_q <= '0;
    end else if (load_now) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        work[k]  <= load_word[k];
        saved[k] <= load_word[k];
      end
      cnt_q <= '0;
    end else if (round_now) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (k == 0) begin
          work[k] <= new_a;
        end else if (k == E_IDX) begin
          work[k] <= new_e;
        end else begin
          work[k] <= work[(k + NUM_WORDS - 1) % NUM_WORDS];
        end
      end
      cnt_q <= last_round ? '0 : cnt_q + CNT_W'(1);
    end else if (state_q == FOLD) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        digest[k] <= saved[k] + work[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
    assign state_out[g*WORD_W +: WORD_W]  = work[g];
    assign digest_out[g*WORD_W +: WORD_W] = digest[g];
  end

  assign round_cnt    = cnt_q;
  assign busy         = (state_q == RUN) || (state_q == FOLD);
  assign digest_valid = (state_q == DONE);

endmodule

// File: tb/tb_sha_state_bank.sv
// tb_sha_state_bank
//   Self-checking bench for sha_state_bank (WORD_W=32, NUM_WORDS=8, ROUNDS=4).
//   A behavioural model of the block tracks the working words, saved hash,
//   digest and handshake; one process compares every DUT output against it
//   shortly after each clock edge and after reset assertion. Directed
//   scenarios add hand-computed literal expectations.
//   Honours SHA_STATE_BANK_MIDSTATE_CACHE_EN (adds reuse_mid and a test).

module tb_sha_state_bank;

  localparam int WW = 32;
  localparam int NW = 8;
  localparam int RN = 4;
  localparam int BW = NW * WW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          reuse_mid;
  logic [BW-1:0] h_in;
  logic          round_en;
  logic [WW-1:0] new_a;
  logic [WW-1:0] new_e;
  logic          digest_ack;
  logic [BW-1:0] state_out;
  logic [1:0]    round_cnt;
  logic          busy;
  logic [BW-1:0] digest_out;
  logic          digest_valid;

  int tests_run;
  int tests_failed;

  sha_state_bank #(.WORD_W(WW), .NUM_WORDS(NW), .ROUNDS(RN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef SHA_STATE_BANK_MIDSTATE_CACHE_EN
    .reuse_mid    (reuse_mid),
`endif
    .h_in         (h_in),
    .round_en     (round_en),
    .new_a        (new_a),
    .new_e        (new_e),
    .digest_ack   (digest_ack),
    .state_out    (state_out),
    .round_cnt    (round_cnt),
    .busy         (busy),
    .digest_out   (digest_out),
    .digest_valid (digest_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: arrays of words plus "running"/"folding"/"valid" flags
  logic [WW-1:0] m_w [NW];
  logic [WW-1:0] m_h [NW];
  logic [WW-1:0] m_d [NW];
  int            m_rounds;
  bit            m_running;
  bit            m_folding;
  bit            m_valid;

  function automatic logic [BW-1:0] pack_words(input logic [WW-1:0] w [NW]);
    logic [BW-1:0] r;
    for (int k = 0; k < NW; k++) r[k*WW +: WW] = w[k];
    return r;
  endfunction

  function automatic logic [BW-1:0] make_hash(input logic [WW-1:0] v0, v1, v2, v3,
                                              v4, v5, v6, v7);
    return {v7, v6, v5, v4, v3, v2, v1, v0};
  endfunction

  task automatic check_output(input string name, input logic [BW-1:0] act,
                              input logic [BW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < NW; k++) begin
      m_w[k] = '0;
      m_h[k] = '0;
      m_d[k] = '0;
    end
    m_rounds  = 0;
    m_running = 0;
    m_folding = 0;
    m_valid   = 0;
  endtask

  task automatic model_step();
    logic [WW-1:0] prev [NW];
    if (m_running) begin
      if (round_en) begin
        prev = m_w;
        for (int k = 1; k < NW; k++) m_w[k] = prev[k-1];
        m_w[0]    = new_a;
        m_w[NW/2] = new_e;
        m_rounds++;
        if (m_rounds == RN) begin
          m_rounds  = 0;
          m_running = 0;
          m_folding = 1;
        end
      end
    end else if (m_folding) begin
      for (int k = 0; k < NW; k++) m_d[k] = m_h[k] + m_w[k];
      m_folding = 0;
      m_valid   = 1;
    end else if (start) begin
      for (int k = 0; k < NW; k++) begin
`ifdef SHA_STATE_BANK_MIDSTATE_CACHE_EN
        if (!reuse_mid) m_h[k] = h_in[k*WW +: WW];
`else
        m_h[k] = h_in[k*WW +: WW];
`endif
        m_w[k] = m_h[k];
      end
      m_rounds  = 0;
      m_running = 1;
      m_valid   = 0;
    end else if (m_valid && digest_ack) begin
      m_valid = 0;
    end
  endtask

  // Model update on each edge (or reset), then compare every output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else        model_step();
    #1;
    check_output("cyc_state_out", state_out, pack_words(m_w));
    check_output("cyc_round_cnt", BW'(round_cnt), BW'(m_rounds));
    check_output("cyc_busy", BW'(busy), BW'(m_running || m_folding));
    check_output("cyc_valid", BW'(digest_valid), BW'(m_valid));
    check_output("cyc_digest", digest_out, pack_words(m_d));
  end

  // Pulse start for one edge (E0) with the given block inputs; returns at
  // the falling edge after E0 with round_en left high.
  task automatic apply_stimulus(input logic [BW-1:0] h, input logic [WW-1:0] a,
                                input logic [WW-1:0] e, input logic ack,
                                input logic reuse);
    @(negedge clk);
    h_in       = h;
    new_a      = a;
    new_e      = e;
    start      = 1'b1;
    digest_ack = ack;
    reuse_mid  = reuse;
    round_en   = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    digest_ack = 1'b0;
    reuse_mid  = 1'b0;
  endtask

  logic [BW-1:0] h_basic, h_next, d_basic, s_basic, h_ones;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_clear();
    start      = 1'b0;
    reuse_mid  = 1'b0;
    h_in       = '0;
    round_en   = 1'b0;
    new_a      = '0;
    new_e      = '0;
    digest_ack = 1'b0;
    rst_n      = 1'b0;

    h_basic = make_hash(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8);
    s_basic = make_hash(32'hA, 32'hA, 32'hA, 32'hA, 32'hE, 32'hE, 32'hE, 32'hE);
    d_basic = make_hash(32'hB, 32'hC, 32'hD, 32'hE, 32'h13, 32'h14, 32'h15, 32'h16);
    h_next  = make_hash(32'h100, 32'h101, 32'h102, 32'h103,
                        32'h104, 32'h105, 32'h106, 32'h107);
    h_ones  = '1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check_output("rst_state_out", state_out, '0);
    check_output("rst_busy", BW'(busy), '0);
    check_output("rst_valid", BW'(digest_valid), '0);
    check_output("rst_digest", digest_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset after two rounds
    apply_stimulus(h_basic, 32'hA, 32'hE, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check_output("pre_rst_cnt", BW'(round_cnt), BW'(2));
    #1;
    rst_n = 1'b0;
    #1;
    check_output("async_state_out", state_out, '0);
    check_output("async_busy", BW'(busy), '0);
    check_output("async_valid", BW'(digest_valid), '0);
    check_output("async_cnt", BW'(round_cnt), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic block
    apply_stimulus(h_basic, 32'hA, 32'hE, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    check_output("basic_state_E4", state_out, s_basic);
    check_output("basic_valid_E4", BW'(digest_valid), '0);
    @(posedge clk);
    #2;
    check_output("basic_digest_E5", digest_out, d_basic);
    check_output("basic_valid_E5", BW'(digest_valid), BW'(1));

    // Handshake: ack withheld, digest held
    @(negedge clk);
    round_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      check_output("hold_valid", BW'(digest_valid), BW'(1));
      check_output("hold_digest", digest_out, d_basic);
    end

`ifdef SHA_STATE_BANK_MIDSTATE_CACHE_EN
    // Midstate: reload from cache with h_in zero
    apply_stimulus('0, 32'hA, 32'hE, 1'b0, 1'b1);
    #(-1 + 1);
    check_output("mid_reload", state_out, h_basic);
    repeat (5) @(posedge clk);
    #2;
    check_output("mid_digest", digest_out, d_basic);
    check_output("mid_valid", BW'(digest_valid), BW'(1));
`endif

    // Start and ack together: start wins
    apply_stimulus(h_next, 32'hA, 32'hE, 1'b1, 1'b0);
    check_output("restart_valid", BW'(digest_valid), '0);
    check_output("restart_busy", BW'(busy), BW'(1));
    check_output("restart_state", state_out, h_next);
    repeat (5) @(posedge clk);
    #2;
    check_output("restart_done", BW'(digest_valid), BW'(1));
    @(negedge clk);
    digest_ack = 1'b1;
    @(negedge clk);
    digest_ack = 1'b0;
    check_output("ack_valid", BW'(digest_valid), '0);
    check_output("ack_busy", BW'(busy), '0);

    // Stall three cycles after round 2
    apply_stimulus(h_basic, 32'hA, 32'hE, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    round_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      check_output("stall_cnt", BW'(round_cnt), BW'(2));
    end
    @(negedge clk);
    round_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_output("stall_valid_E7", BW'(digest_valid), '0);
    @(posedge clk);
    #2;
    check_output("stall_valid_E8", BW'(digest_valid), BW'(1));
    check_output("stall_digest", digest_out, d_basic);

    // Per-word carry discard
    apply_stimulus(h_ones, 32'h1, 32'h1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    check_output("wrap_digest", digest_out, '0);
    check_output("wrap_valid", BW'(digest_valid), BW'(1));

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
